feature_stream_tx: RTL

FEATURE_STREAM_TX -- requirements
Module: feature_stream_tx

---
 rtl/feature_stream_tx.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/feature_stream_tx.sv
// feature_stream_tx
//   Reads a CHW feature map out of a buffer (channel fastest, then column,
//   then row) and streams it to a ready/valid consumer along with the
//   (channel,row,col) coordinates of every element.
//
//   Optional build macro: FSTX_FRAME_CNT_EN enables the completed-frame
//   counter on frame_count; without it frame_count is tied to zero.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   start, enable       frame request (sampled in IDLE), read-issue permit
//   mem_rd_en/addr      buffer read request; mem_rd_data returns one cycle later
//   valid_out/ready_in  output handshake; data_out + channel/row/col_out payload
//   busy, done          frame in progress, one-cycle end-of-frame pulse
//   frame_count         completed frames (optional)
module feature_stream_tx #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_CH     = 16,
    parameter int IMG_H      = 112,
    parameter int IMG_W      = 112,
    parameter int ADDR_WIDTH = 18
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  enable,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_rd_addr,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    output logic                  valid_out,
    input  logic                  ready_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic [7:0]            channel_out,
    output logic [7:0]            row_out,
    output logic [7:0]            col_out,
    output logic                  busy,
    output logic                  done,
    output logic [15:0]           frame_count
);

    localparam int                    TOTAL     = NUM_CH * IMG_H * IMG_W;
    localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = ADDR_WIDTH'(TOTAL - 1);
    localparam logic [7:0]            CH_LAST   = 8'(NUM_CH - 1);
    localparam logic [7:0]            COL_LAST  = 8'(IMG_W - 1);

    typedef enum logic [1:0] {IDLE, STREAM, DRAIN, FINISH} state_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic [7:0]            ch;
        logic [7:0]            row;
        logic [7:0]            col;
    } entry_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] addr_p0;
    logic [7:0]            ch_p0, row_p0, col_p0;
    logic                  vld_p1;
    logic [7:0]            ch_p1, row_p1, col_p1;
    entry_t                head, tail, push_ent;
    logic [1:0]            fifo_cnt;
    logic [2:0]            occ;
    logic                  pop, last_issue, last_beat;

    assign valid_out   = (fifo_cnt != 2'd0);
    assign pop         = valid_out && ready_in;
    // Occupancy the FIFO will have once this cycle's push/pop settle; a new
    // read is only issued if its data is guaranteed a free slot.
    assign occ         = 3'(fifo_cnt) + 3'(vld_p1) - 3'(pop);
    assign mem_rd_en   = (state == STREAM) && enable && (occ < 3'd2);
    assign mem_rd_addr = addr_p0;
    assign last_issue  = mem_rd_en && (addr_p0 == ADDR_LAST);
    // In DRAIN nothing new is issued, so the last beat is the only entry left.
    assign last_beat   = (state == DRAIN) && pop && (fifo_cnt == 2'd1) && !vld_p1;
    assign push_ent    = {mem_rd_data, ch_p1, row_p1, col_p1};

    assign data_out    = head.data;
    assign channel_out = head.ch;
    assign row_out     = head.row;
    assign col_out     = head.col;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start && enable) begin
                    state <= STREAM;
                    busy  <= 1'b1;
                end
                STREAM: if (last_issue) state <= DRAIN;
                DRAIN: if (last_beat) begin
                    state <= FINISH;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
                FINISH: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Stage 0: issue address and coordinate counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_p0 <= '0;
            ch_p0   <= '0;
            row_p0  <= '0;
            col_p0  <= '0;
            vld_p1  <= 1'b0;
            ch_p1   <= '0;
            row_p1  <= '0;
            col_p1  <= '0;
        end else begin
            vld_p1 <= mem_rd_en;
            if (mem_rd_en) begin
                ch_p1  <= ch_p0;
                row_p1 <= row_p0;
                col_p1 <= col_p0;
                if (last_issue) begin
                    addr_p0 <= '0;
                    ch_p0   <= '0;
                    row_p0  <= '0;
                    col_p0  <= '0;
                end else begin
                    addr_p0 <= addr_p0 + ADDR_WIDTH'(1);
                    if (ch_p0 == CH_LAST) begin
                        ch_p0 <= '0;
                        if (col_p0 == COL_LAST) begin
                            col_p0 <= '0;
                            row_p0 <= row_p0 + 8'd1;
                        end else begin
                            col_p0 <= col_p0 + 8'd1;
                        end
                    end else begin
                        ch_p0 <= ch_p0 + 8'd1;
                    end
                end
            end
        end
    end

    // Stage 1: returned data (vld_p1) lands in the 2-entry output FIFO
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_cnt <= 2'd0;
            head     <= '0;
            tail     <= '0;
        end else begin
            case (fifo_cnt)
                2'd0: if (vld_p1) begin
                    head     <= push_ent;
                    fifo_cnt <= 2'd1;
                end
                2'd1: begin
                    if (vld_p1 && pop) begin
                        head <= push_ent;
                    end else if (vld_p1) begin
                        tail     <= push_ent;
                        fifo_cnt <= 2'd2;
                    end else if (pop) begin
                        fifo_cnt <= 2'd0;
                    end
                end
                2'd2: if (pop) begin
                    head <= tail;
                    if (vld_p1) tail <= push_ent;
                    else        fifo_cnt <= 2'd1;
                end
                default: fifo_cnt <= 2'd0;
            endcase
        end
    end

`ifdef FSTX_FRAME_CNT_EN
    logic [15:0] frame_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                frame_cnt_q <= 16'd0;
        else if (state == FINISH)  frame_cnt_q <= frame_cnt_q + 16'd1;
    end

    assign frame_count = frame_cnt_q;
`else
    assign frame_count = 16'd0;
`endif

endmodule
